// File: rtl/cpu_pipe_pkg.sv
// Shared state encoding and default per-stage widths for the core's pipeline registers.
package cpu_pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_t;

   localparam int IFID_DATA_W  = 96;
   localparam int IFID_CTRL_W  = 4;
   localparam int IDEX_DATA_W  = 64;
   localparam int IDEX_CTRL_W  = 8;
   localparam int EXMEM_DATA_W = 64;
   localparam int EXMEM_CTRL_W = 6;
   localparam int MEMWB_DATA_W = 64;
   localparam int MEMWB_CTRL_W = 3;

   // Entries lost on a flush: everything held plus an offered input, minus one that left anyway.
   function automatic logic [1:0] dropCount(input logic [1:0] occ,
                                            input logic       inTaken,
                                            input logic       outTaken);
      return occ + {1'b0, inTaken} - {1'b0, outTaken};
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with a 0..3 increment and synchronous clear.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_clear,
   input  logic [1:0]       i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W:0]   w_sum;

   assign w_sum   = {1'b0, r_count} + {{(CNT_W-1){1'b0}}, i_inc};
   assign o_count = r_count;

   // A carry out of the top bit means the count would wrap, so pin it at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_count <= '0;
      end else if (w_sum[CNT_W]) begin
         r_count <= '1;
      end else begin
         r_count <= w_sum[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer, flush and drop counter.
module pipe_stage_reg
   import cpu_pipe_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int CTRL_W     = 8,
   parameter int SKID       = 1,
   parameter int FLUSH_COMB = 1,
   parameter int CNT_W      = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  drop_cnt
);

   pipe_state_t       r_state;
   logic [DATA_W-1:0] r_mData;
   logic [CTRL_W-1:0] r_mCtrl;
   logic [DATA_W-1:0] r_sData;
   logic [CTRL_W-1:0] r_sCtrl;

   logic       w_flushMask;
   logic       w_outValid;
   logic       w_inReady;
   logic       w_inFire;
   logic       w_outFire;
   logic [1:0] w_occ;
   logic [1:0] w_dropInc;

   assign w_flushMask = flush & (FLUSH_COMB != 0);
   assign w_outValid  = (r_state != ST_EMPTY) & ~w_flushMask;

   // With the skid entry, in_ready is a pure state decode so it never depends on out_ready.
   assign w_inReady = (SKID != 0) ? (r_state != ST_TWO) : (~w_outValid | out_ready);

   assign w_inFire  = in_valid & w_inReady & ~flush;
   assign w_outFire = w_outValid & out_ready;
   assign w_occ     = r_state;
   assign w_dropInc = flush ? dropCount(w_occ, in_valid & w_inReady, w_outFire) : 2'd0;

   assign in_ready  = w_inReady;
   assign out_valid = w_outValid;
   assign out_data  = r_mData;
   assign out_ctrl  = w_outValid ? r_mCtrl : '0;
   assign occ       = w_occ;

   // M always holds the oldest entry; S only fills when M is stalled, keeping strict FIFO order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_EMPTY;
         r_mData <= '0;
         r_mCtrl <= '0;
         r_sData <= '0;
         r_sCtrl <= '0;
      end else if (flush) begin
         r_state <= ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_inFire) begin
                  r_mData <= in_data;
                  r_mCtrl <= in_ctrl;
                  r_state <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_inFire && (w_outFire || (SKID == 0))) begin
                  r_mData <= in_data;
                  r_mCtrl <= in_ctrl;
               end else if (w_inFire) begin
                  r_sData <= in_data;
                  r_sCtrl <= in_ctrl;
                  r_state <= ST_TWO;
               end else if (w_outFire) begin
                  r_state <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_outFire) begin
                  r_mData <= r_sData;
                  r_mCtrl <= r_sCtrl;
                  r_state <= ST_ONE;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_dropCounter (
      .i_clk   (CLK),
      .i_clear (RST),
      .i_inc   (w_dropInc),
      .o_count (drop_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue-based reference model per instance, directed plus random traffic.
module tb_pipe_stage_reg;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  ctrl;
   } item_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;

   logic        aValid = 1'b0, aFlush = 1'b0, aOutReady = 1'b0;
   logic [63:0] aData = '0;
   logic [7:0]  aCtrl = '0;
   logic        aInReady, aOutValid, bInReady, bOutValid;
   logic [63:0] aOutData, bOutData;
   logic [7:0]  aOutCtrl, bOutCtrl;
   logic [1:0]  aOcc, bOcc;
   logic [15:0] aDropCnt;
   logic [1:0]  bDropCnt;

   logic        cValid = 1'b0, cFlush = 1'b0, cOutReady = 1'b0;
   logic [63:0] cData = '0;
   logic [7:0]  cCtrl = '0;
   logic        cInReady, cOutValid;
   logic [63:0] cOutData;
   logic [7:0]  cOutCtrl;
   logic [1:0]  cOcc;
   logic [15:0] cDropCnt;

   int checks = 0;
   int passes = 0;

   item_t       aQ[$];
   item_t       cQ[$];
   int          aDrop = 0, bDrop = 0, cDrop = 0;
   logic [63:0] aLast = '0, cLast = '0;
   logic        modelLive = 1'b0;

   always #5 CLK = ~CLK;

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .FLUSH_COMB(1), .CNT_W(16)) dutA (
      .CLK(CLK), .RST(RST), .in_valid(aValid), .in_ready(aInReady), .in_data(aData),
      .in_ctrl(aCtrl), .flush(aFlush), .out_valid(aOutValid), .out_ready(aOutReady),
      .out_data(aOutData), .out_ctrl(aOutCtrl), .occ(aOcc), .drop_cnt(aDropCnt));

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .FLUSH_COMB(1), .CNT_W(2)) dutB (
      .CLK(CLK), .RST(RST), .in_valid(aValid), .in_ready(bInReady), .in_data(aData),
      .in_ctrl(aCtrl), .flush(aFlush), .out_valid(bOutValid), .out_ready(aOutReady),
      .out_data(bOutData), .out_ctrl(bOutCtrl), .occ(bOcc), .drop_cnt(bDropCnt));

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0), .FLUSH_COMB(0), .CNT_W(16)) dutC (
      .CLK(CLK), .RST(RST), .in_valid(cValid), .in_ready(cInReady), .in_data(cData),
      .in_ctrl(cCtrl), .flush(cFlush), .out_valid(cOutValid), .out_ready(cOutReady),
      .out_data(cOutData), .out_ctrl(cOutCtrl), .occ(cOcc), .drop_cnt(cDropCnt));

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [7:0] c,
                                input logic ordy, input logic fl);
      @(posedge CLK);
      #1;
      aValid = v; aData = d; aCtrl = c; aOutReady = ordy; aFlush = fl;
   endtask

   task automatic applyStimulusC(input logic v, input logic [63:0] d, input logic [7:0] c,
                                 input logic ordy, input logic fl);
      @(posedge CLK);
      #1;
      cValid = v; cData = d; cCtrl = c; cOutReady = ordy; cFlush = fl;
   endtask

   // Reference model: each stage is a FIFO of at most 2 (A/B) or 1 (C) entries, updated at the
   // negedge from the inputs that will be sampled at the next rising edge.
   always @(negedge CLK) begin
      item_t it;
      int    n;
      logic  expReady, expValid, outFire, inTaken;
      if (RST) begin
         aQ.delete(); cQ.delete();
         aDrop = 0; bDrop = 0; cDrop = 0;
         aLast = '0; cLast = '0;
         modelLive = 1'b1;
      end else if (modelLive) begin
         expReady = (aQ.size() < 2);
         expValid = (aQ.size() > 0) && !aFlush;
         if (aQ.size() > 0) aLast = aQ[0].data;
         checkOutput("A occ", 64'(aOcc), 64'(aQ.size()));
         checkOutput("B occ", 64'(bOcc), 64'(aQ.size()));
         checkOutput("A in_ready", 64'(aInReady), 64'(expReady));
         checkOutput("A out_valid", 64'(aOutValid), 64'(expValid));
         checkOutput("A out_ctrl", 64'(aOutCtrl), expValid ? 64'(aQ[0].ctrl) : 64'd0);
         checkOutput("A out_data", aOutData, aLast);
         checkOutput("A drop_cnt", 64'(aDropCnt), 64'(aDrop));
         checkOutput("B drop_cnt", 64'(bDropCnt), 64'(bDrop));
         inTaken = aValid && expReady;
         if (aFlush) begin
            n = aQ.size() + (inTaken ? 1 : 0);
            aDrop = (aDrop + n > 65535) ? 65535 : aDrop + n;
            bDrop = (bDrop + n > 3) ? 3 : bDrop + n;
            aQ.delete();
         end else begin
            if (expValid && aOutReady) begin
               it = aQ.pop_front();
               checkOutput("A pop data", aOutData, it.data);
               checkOutput("A pop ctrl", 64'(aOutCtrl), 64'(it.ctrl));
            end
            if (inTaken) aQ.push_back('{data: aData, ctrl: aCtrl});
         end

         expValid = (cQ.size() > 0);
         expReady = !expValid || cOutReady;
         if (cQ.size() > 0) cLast = cQ[0].data;
         checkOutput("C occ", 64'(cOcc), 64'(cQ.size()));
         checkOutput("C in_ready", 64'(cInReady), 64'(expReady));
         checkOutput("C out_valid", 64'(cOutValid), 64'(expValid));
         checkOutput("C out_ctrl", 64'(cOutCtrl), expValid ? 64'(cQ[0].ctrl) : 64'd0);
         checkOutput("C out_data", cOutData, cLast);
         checkOutput("C drop_cnt", 64'(cDropCnt), 64'(cDrop));
         outFire = expValid && cOutReady;
         inTaken = cValid && expReady;
         if (outFire) begin
            it = cQ.pop_front();
            checkOutput("C pop data", cOutData, it.data);
            checkOutput("C pop ctrl", 64'(cOutCtrl), 64'(it.ctrl));
         end
         if (cFlush) begin
            n = cQ.size() + (inTaken ? 1 : 0);
            cDrop = (cDrop + n > 65535) ? 65535 : cDrop + n;
            cQ.delete();
         end else if (inTaken) begin
            cQ.push_back('{data: cData, ctrl: cCtrl});
         end
      end
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      @(negedge CLK);
      checkOutput("reset occ", 64'(aOcc), 64'd0);
      checkOutput("reset out_valid", 64'(aOutValid), 64'd0);
      checkOutput("reset in_ready", 64'(aInReady), 64'd1);
      checkOutput("reset out_data", aOutData, 64'd0);
      checkOutput("reset drop_cnt", 64'(aDropCnt), 64'd0);

      // Back-to-back pass-through
      applyStimulus(1'b1, 64'h11, 8'h01, 1'b1, 1'b0);
      applyStimulus(1'b1, 64'h22, 8'h02, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("pass first out_valid", 64'(aOutValid), 64'd1);
      checkOutput("pass first data", aOutData, 64'h11);
      applyStimulus(1'b1, 64'h33, 8'h03, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("pass second data", aOutData, 64'h22);
      checkOutput("pass occ", 64'(aOcc), 64'd1);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

      // Backpressure into the skid entry
      applyStimulus(1'b1, 64'hA1, 8'h0A, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hA2, 8'h0B, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hA3, 8'h0C, 1'b0, 1'b0);
      @(negedge CLK);
      checkOutput("skid occ", 64'(aOcc), 64'd2);
      checkOutput("skid in_ready", 64'(aInReady), 64'd0);
      checkOutput("skid hold data", aOutData, 64'hA1);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("skid second data", aOutData, 64'hA2);
      checkOutput("skid in_ready back", 64'(aInReady), 64'd1);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

      // Control masking once the stage drains
      applyStimulus(1'b1, 64'h5C, 8'hFF, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("mask ctrl live", 64'(aOutCtrl), 64'hFF);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("mask out_valid", 64'(aOutValid), 64'd0);
      checkOutput("mask out_ctrl", 64'(aOutCtrl), 64'd0);
      checkOutput("mask data held", aOutData, 64'h5C);

      // Flush in TWO, then in ONE, then TWO again to saturate the 2-bit counter
      applyStimulus(1'b1, 64'hB1, 8'h0F, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hB2, 8'h0F, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hB3, 8'h0F, 1'b1, 1'b1);
      @(negedge CLK);
      checkOutput("flush same-cycle valid", 64'(aOutValid), 64'd0);
      checkOutput("flush same-cycle ctrl", 64'(aOutCtrl), 64'd0);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("flush TWO occ", 64'(aOcc), 64'd0);
      checkOutput("flush TWO drop", 64'(aDropCnt), 64'd2);
      checkOutput("sat drop 1", 64'(bDropCnt), 64'd2);
      applyStimulus(1'b1, 64'hC1, 8'h0F, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hC2, 8'h0F, 1'b0, 1'b1);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("flush ONE drop", 64'(aDropCnt), 64'd4);
      checkOutput("sat drop 2", 64'(bDropCnt), 64'd3);
      applyStimulus(1'b1, 64'hB4, 8'h0F, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hB5, 8'h0F, 1'b0, 1'b0);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("flush third drop", 64'(aDropCnt), 64'd6);
      checkOutput("sat drop 3", 64'(bDropCnt), 64'd3);

      // Reset while stalled with both entries held
      applyStimulus(1'b1, 64'hD1, 8'h01, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'hD2, 8'h02, 1'b0, 1'b0);
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
      @(negedge CLK);
      checkOutput("stall occ", 64'(aOcc), 64'd2);
      @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      checkOutput("rst stall occ", 64'(aOcc), 64'd0);
      checkOutput("rst stall out_valid", 64'(aOutValid), 64'd0);
      checkOutput("rst stall drop", 64'(aDropCnt), 64'd0);

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(3) != 0, {$urandom, $urandom}, 8'($urandom),
                       $urandom_range(2) != 0, $urandom_range(19) == 0);
      end
      applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);

      // Single-entry variant: in_ready follows out_ready combinationally
      applyStimulusC(1'b1, 64'hE1, 8'h21, 1'b1, 1'b0);
      applyStimulusC(1'b1, 64'hE2, 8'h22, 1'b0, 1'b0);
      @(negedge CLK);
      checkOutput("C stalled in_ready", 64'(cInReady), 64'd0);
      applyStimulusC(1'b1, 64'hE3, 8'h23, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("C released in_ready", 64'(cInReady), 64'd1);
      for (int i = 0; i < 300; i++) begin
         applyStimulusC($urandom_range(3) != 0, {$urandom, $urandom}, 8'($urandom),
                        $urandom_range(1) != 0, (i >= 40) && ($urandom_range(15) == 0));
      end
      applyStimulusC(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      applyStimulusC(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      @(negedge CLK);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
